// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//
// Multi-channel clock divider and tick generator. Each of N_CH channels divides
// the system clock by 2*H, where H is a runtime-reloadable half-period (a value
// of 0 behaves as 1). The outputs are a 50 % duty divided clock and a
// one-cycle tick that coincides with each rising edge of that divided clock.
//
// New half-periods are written to a per-channel shadow register. The shadow is
// copied into the active register only at the next wrap, so the half-period
// already in progress always completes and the output never glitches.
//
// Parameters
//   N_CH      number of independent channels (1..8)
//   CNT_W     counter and half-period width in bits
//   DEF_HALF  packed reset half-periods, channel i at [i*CNT_W +: CNT_W]
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset; discards pending shadows
//   en        per-channel run enable; a disabled channel freezes in place
//   sync_clr  synchronous restart of all channels (overrides en)
//   ld        one-cycle load strobe
//   ld_ch     target channel for ld; indices >= N_CH are ignored
//   ld_half   new half-period in clk cycles
//   clk_out   divided clocks, registered
//   tick      one-cycle pulse on each rising edge of clk_out, registered
// -----------------------------------------------------------------------------
module clk_div_multi #(
  parameter int unsigned              N_CH     = 3,
  parameter int unsigned              CNT_W    = 32,
  parameter logic [N_CH*CNT_W-1:0]    DEF_HALF = {32'd24_999_999, 32'd12_499_999, 32'd24_999}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic             sync_clr,
  input  logic             ld,
  input  logic [2:0]       ld_ch,
  input  logic [CNT_W-1:0] ld_half,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Complete state of one divider channel. Every field is a register, so both
  // outputs come straight from flops with no combinational input path.
  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_half;
    logic [CNT_W-1:0] shd_half;
    logic             shd_vld;
    logic             clk_out;
    logic             tick;
  } ch_state_t;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch

    ch_state_t        ch_q;
    ch_state_t        ch_d;
    logic [CNT_W-1:0] half_eff;
    logic             tc;
    logic             wrap;
    logic             ld_hit;

    // ld_ch is 3 bits wide and gi never exceeds N_CH-1, so an out-of-range
    // index simply matches no channel and the load is dropped.
    assign ld_hit = ld && (ld_ch == 3'(gi));

    // A programmed half-period of zero is treated as one.
    assign half_eff = (ch_q.act_half == '0) ? ONE : ch_q.act_half;

    // ">=" rather than "==" so a count left above the terminal value by a
    // shortened reload wraps on the next enabled cycle instead of running
    // all the way round the counter.
    assign tc   = (ch_q.cnt >= (half_eff - ONE));
    assign wrap = en[gi] && tc;

    // NOTE: every field of ch_d is given a value (ch_q) before any branch, so
    // no path through this block leaves a signal unassigned and no latch is
    // inferred.
    always_comb begin
      ch_d      = ch_q;
      ch_d.tick = 1'b0;

      if (sync_clr) begin
        // Restart: divided clock low, count from zero. A load arriving in the
        // same cycle is newer than any pending shadow, so it takes priority.
        ch_d.cnt     = '0;
        ch_d.clk_out = 1'b0;
        if (ld_hit) begin
          ch_d.act_half = ld_half;
          ch_d.shd_half = ld_half;
          ch_d.shd_vld  = 1'b0;
        end else if (ch_q.shd_vld) begin
          ch_d.act_half = ch_q.shd_half;
          ch_d.shd_vld  = 1'b0;
        end
      end else begin
        // Counting. A disabled channel keeps cnt and clk_out untouched.
        if (en[gi]) begin
          if (tc) begin
            ch_d.cnt     = '0;
            ch_d.clk_out = ~ch_q.clk_out;
            ch_d.tick    = ~ch_q.clk_out;  // only on the 0 -> 1 transition
          end else begin
            ch_d.cnt = ch_q.cnt + ONE;     // wraps modulo 2^CNT_W
          end
        end

        // Half-period update. At a wrap the new value can go straight into
        // the active register because the next half-period has not started.
        // Otherwise it waits in the shadow; a later load overwrites an
        // earlier one, so the last load before the wrap wins.
        if (ld_hit) begin
          ch_d.shd_half = ld_half;
          if (wrap) begin
            ch_d.act_half = ld_half;
            ch_d.shd_vld  = 1'b0;
          end else begin
            ch_d.shd_vld  = 1'b1;
          end
        end else if (wrap && ch_q.shd_vld) begin
          ch_d.act_half = ch_q.shd_half;
          ch_d.shd_vld  = 1'b0;
        end
      end
    end

    // NOTE: state registers are updated only with non-blocking assignments so
    // every channel samples the same pre-edge values regardless of evaluation
    // order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // All per-channel state is a handful of flops (no memory array), so
        // every field is reset; pending shadows are discarded.
        ch_q.cnt      <= '0;
        ch_q.act_half <= DEF_HALF[gi*CNT_W +: CNT_W];
        ch_q.shd_half <= DEF_HALF[gi*CNT_W +: CNT_W];
        ch_q.shd_vld  <= 1'b0;
        ch_q.clk_out  <= 1'b0;
        ch_q.tick     <= 1'b0;
      end else begin
        ch_q <= ch_d;
      end
    end

    assign clk_out[gi] = ch_q.clk_out;
    assign tick[gi]    = ch_q.tick;

  end : g_ch

endmodule : clk_div_multi

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider and tick generator for the digital alarm. It replaces fixed single-ratio dividers with N_CH independent channels, each producing a 50 % duty divided clock and a one-cycle tick strobe from the 50 MHz system clock. Typical channels are 1 kHz display scan, 2 Hz blink and 1 Hz timekeeping. Each channel has a per-channel enable, a runtime-reloadable half-period applied glitch-free at the next wrap, and a global synchronous restart.

## Interface
Parameters:
- N_CH, 3: number of independent divider channels (1..8).
- CNT_W, 32: counter and half-period width in bits.
- DEF_HALF, {32'd24_999_999, 32'd12_499_999, 32'd24_999}: packed N_CH*CNT_W reset half-periods; channel i occupies bits [i*CNT_W +: CNT_W].

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- en  in  N_CH  per-channel run enable.
- sync_clr  in  1  synchronous restart of all channels.
- ld  in  1  one-cycle load strobe for a new half-period.
- ld_ch  in  3  target channel index for ld.
- ld_half  in  CNT_W  new half-period in clk cycles.
- clk_out  out  N_CH  divided clocks, 50 % duty.
- tick  out  N_CH  one-cycle pulse, asserted coincident with each rising edge of clk_out.

## Operation
- Per-channel state: cnt (CNT_W), act_half (active), shd_half (shadow), shd_vld, clk_out, tick.
- Reset values: cnt=0, clk_out=0, tick=0, act_half=shd_half=DEF_HALF slice, shd_vld=0.
- Effective half H = max(act_half, 1). A half-period value of 0 is treated as 1.
- Terminal count TC is cnt >= H-1. The >= comparison guarantees recovery from any out-of-range count.
- Channel running (en[i]=1, sync_clr=0):
  - Not TC: cnt+1, clk_out holds, tick=0.
  - TC: cnt<=0 and clk_out toggles. tick=1 only when clk_out goes 0->1.
  - On the TC cycle, if shd_vld, then act_half<=shd_half and shd_vld<=0.
- en[i]=0: cnt and clk_out freeze, tick=0. Resuming continues from the frozen count.
- Load: when ld=1 and ld_ch<N_CH, shd_half[ld_ch]<=ld_half and shd_vld<=1. Loads with ld_ch>=N_CH are ignored.
  - Repeated loads before the next wrap: the last one wins.
  - Load in the same cycle as that channel's TC: ld_half goes directly into act_half and shd_vld stays 0. The new value governs the very next half-period.
- sync_clr=1 (overrides en and TC) for all channels:
  - cnt<=0, clk_out<=0, tick<=0.
  - A pending shadow is applied immediately.
  - A load in the same cycle is applied directly to act_half.
- Width: cnt increments modulo 2^CNT_W. Output period = 2*H clk cycles, with clk_out high for H cycles and low for H cycles.

## Timing
- All outputs are registered with no combinational path from inputs to outputs.
- First rising edge after reset or sync_clr with en=1 occurs H cycles later: clk_out and tick go high together on the H-th clk edge.
- tick is high for exactly 1 cycle per 2*H cycles.
- Reload latency: the new value takes effect at the first wrap after ld, so the in-progress half-period always completes (glitch-free).
- rst_n is asynchronous assert / synchronous-deassert-safe: everything returns to reset values immediately, mid-period included, and shadows are discarded.

## Test plan
- Bench config: N_CH=2, CNT_W=8, DEF_HALF={8'd5, 8'd3}.
1. Reset, en=2'b11 -> ch0 clk_out rises on cycle 3 and has period 6; ch1 rises on cycle 5 and has period 10. tick ch0 pulses on cycles 3, 9, 15; each pulse is 1 cycle.
2. ld ch0 with ld_half=2 mid-high-phase -> current half-period completes at 3 cycles, then period becomes 4. Two loads (4 then 6) before the wrap -> period 12 applied.
3. en[0] dropped for 7 cycles at cnt=1 -> clk_out[0] frozen, tick[0]=0. After en returns, the toggle occurs 2 cycles later.
4. sync_clr with a pending shadow of 1 -> both clk_out go 0 next cycle; ch0 then toggles every cycle with a period of 2.
5. ld_half=0 -> behaves as 1 (period 2). ld_ch=3 -> no change on either channel. Load coincident with TC -> new H is used immediately.
6. rst_n asserted asynchronously mid-cycle -> clk_out=0 and tick=0 without waiting for a clk edge; DEF_HALF is restored.
